ahb_lite_master: RTL and testbench

- AHB initiator: converts a simple request/response command port into single (hburst SINGLE) AHB transfers on the 32-bit bus signal set the team's bus interface carries.
- Issues NONSEQ transfers with pipelined address and data phases, honours hready wait states, and handles two-cycle ERROR/RETRY/SPLIT responses.
- Sits between a CPU-side or testbench-side command source and the AHB decoder/slave fabric, e.g. driving the UART register block.

---
 rtl/ahb_pkg.sv | 48 ++++
 rtl/ahb_lite_master.sv | 164 ++++++++++++++++
 tb/tb_ahb_lite_master.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types: transfer/response encodings and the command payload
// carried through the master's address, data and replay slots.
package ahb_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SIZE_W  = 3;
  localparam int unsigned RETRY_W = 8;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01,
    HRESP_RETRY = 2'b10,
    HRESP_SPLIT = 2'b11
  } hresp_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'b000,
    HSIZE_HALF = 3'b001,
    HSIZE_WORD = 3'b010
  } hsize_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000
  } hburst_e;

  typedef enum logic [1:0] {
    D_IDLE   = 2'b00,
    D_ACTIVE = 2'b01,
    D_RESP1  = 2'b10
  } dstate_e;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              write;
    logic [SIZE_W-1:0] size;
  } ahb_cmd_t;

endpackage

// File: rtl/ahb_lite_master.sv
// AHB-Lite initiator: turns a request/response command port into pipelined
// SINGLE transfers, with wait states and two-cycle ERROR/RETRY/SPLIT handling.
module ahb_lite_master
  import ahb_pkg::*;
#(
  parameter int unsigned MAX_RETRY = 15
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              req_write,
  input  logic [SIZE_W-1:0] req_size,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] haddr,
  output logic [1:0]        htrans,
  output logic              hwrite,
  output logic [SIZE_W-1:0] hsize,
  output logic [2:0]        hburst,
  output logic [DATA_W-1:0] hwdata,
  input  logic [DATA_W-1:0] hrdata,
  input  logic              hready,
  input  logic [1:0]        hresp
);

  localparam logic [RETRY_W-1:0] MAX_RETRY_C = RETRY_W'(MAX_RETRY);

  ahb_cmd_t          r_a, r_d, r_r;
  ahb_cmd_t          w_a_nxt, w_d_nxt, w_r_nxt, w_sel, w_issue_cmd;
  dstate_e           r_dstate, w_dstate_nxt;
  htrans_e           r_htrans;
  hresp_e            r_first_resp;
  logic [ADDR_W-1:0] r_haddr;
  logic              r_hwrite;
  logic [SIZE_W-1:0] r_hsize;
  logic              r_rsp_valid, r_rsp_err;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic [RETRY_W-1:0] r_retry_cnt;
  logic w_advance, w_bus_valid, w_load, w_req_ready, w_accept, w_issue;
  logic w_done, w_err, w_replay;

  // The command on the bus is the replay slot if occupied, else the A-slot.
  assign w_advance   = hready && (r_dstate != D_RESP1);
  assign w_bus_valid = (r_htrans == HTRANS_NONSEQ);
  assign w_load      = w_advance && w_bus_valid;
  assign w_sel       = r_r.valid ? r_r : r_a;
  assign w_req_ready = !r_r.valid && (!r_a.valid || w_advance);
  assign w_accept    = req_valid && w_req_ready;

  // Data-phase FSM: state register.
  always_ff @(posedge hclk) begin
    if (hreset) r_dstate <= D_IDLE;
    else        r_dstate <= w_dstate_nxt;
  end

  // Data-phase FSM: next state.
  always_comb begin
    w_dstate_nxt = r_dstate;
    case (r_dstate)
      D_IDLE:   w_dstate_nxt = w_load ? D_ACTIVE : D_IDLE;
      D_ACTIVE: begin
        if (hready)                   w_dstate_nxt = w_load ? D_ACTIVE : D_IDLE;
        else if (hresp != HRESP_OKAY) w_dstate_nxt = D_RESP1;
      end
      D_RESP1:  if (hready) w_dstate_nxt = D_IDLE;
      default:  w_dstate_nxt = D_IDLE;
    endcase
  end

  // Data-phase FSM: completion outputs; a response that changes mid-pair is an ERROR.
  always_comb begin
    w_done   = 1'b0;
    w_err    = 1'b0;
    w_replay = 1'b0;
    case (r_dstate)
      D_ACTIVE: if (hready) begin
        w_done = 1'b1;
        w_err  = (hresp != HRESP_OKAY);
      end
      D_RESP1: if (hready) begin
        if ((r_first_resp == HRESP_ERROR) || (hresp != r_first_resp)) begin
          w_done = 1'b1;
          w_err  = 1'b1;
        end else if (r_retry_cnt < MAX_RETRY_C) begin
          w_replay = 1'b1;
        end else begin
          w_done = 1'b1;
          w_err  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Slot movement and selection of next cycle's address-phase command.
  always_comb begin
    w_a_nxt = r_a;
    w_d_nxt = r_d;
    w_r_nxt = r_r;
    if (w_load) begin
      w_d_nxt = w_sel;
      if (r_r.valid) w_r_nxt.valid = 1'b0;
      else           w_a_nxt.valid = 1'b0;
    end else if (w_done || w_replay) begin
      w_d_nxt.valid = 1'b0;
    end
    if (w_replay) w_r_nxt = r_d;
    if (w_accept) w_a_nxt = '{valid: 1'b1, addr: req_addr, wdata: req_wdata,
                              write: req_write, size: req_size};
    w_issue     = (w_r_nxt.valid || w_a_nxt.valid) && (w_dstate_nxt != D_RESP1);
    w_issue_cmd = w_r_nxt.valid ? w_r_nxt : w_a_nxt;
  end

  // Slot registers, registered bus outputs, response and retry bookkeeping.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_a          <= '0;
      r_d          <= '0;
      r_r          <= '0;
      r_htrans     <= HTRANS_IDLE;
      r_haddr      <= '0;
      r_hwrite     <= 1'b0;
      r_hsize      <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_rsp_rdata  <= '0;
      r_retry_cnt  <= '0;
      r_first_resp <= HRESP_OKAY;
    end else begin
      r_a         <= w_a_nxt;
      r_d         <= w_d_nxt;
      r_r         <= w_r_nxt;
      r_htrans    <= w_issue ? HTRANS_NONSEQ : HTRANS_IDLE;
      if (w_issue) begin
        r_haddr  <= w_issue_cmd.addr;
        r_hwrite <= w_issue_cmd.write;
        r_hsize  <= w_issue_cmd.size;
      end
      r_rsp_valid <= w_done;
      r_rsp_err   <= w_done && w_err;
      if (w_done) r_rsp_rdata <= (!r_d.write && !w_err) ? hrdata : '0;
      if (w_replay)    r_retry_cnt <= r_retry_cnt + RETRY_W'(1);
      else if (w_done) r_retry_cnt <= '0;
      if ((r_dstate == D_ACTIVE) && !hready && (hresp != HRESP_OKAY))
        r_first_resp <= hresp_e'(hresp);
    end
  end

  assign req_ready = w_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign haddr     = r_haddr;
  assign htrans    = r_htrans;
  assign hwrite    = r_hwrite;
  assign hsize     = r_hsize;
  assign hburst    = HBURST_SINGLE;
  assign hwdata    = r_d.wdata;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed bench for ahb_lite_master: a default instance plus a MAX_RETRY=1
// instance sharing all inputs; expected values are hand-computed per cycle.
module tb_ahb_lite_master;
  import ahb_pkg::*;

  logic        hclk, hreset;
  logic        req_valid, req_write;
  logic [31:0] req_addr, req_wdata, hrdata;
  logic [2:0]  req_size;
  logic        hready;
  logic [1:0]  hresp;

  logic        req_ready, rsp_valid, rsp_err, hwrite;
  logic [31:0] rsp_rdata, haddr, hwdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize, hburst;

  logic        u2_req_ready, u2_rsp_valid, u2_rsp_err, u2_hwrite;
  logic [31:0] u2_rsp_rdata, u2_haddr, u2_hwdata;
  logic [1:0]  u2_htrans;
  logic [2:0]  u2_hsize, u2_hburst;

  int checks = 0;
  int errors = 0;

  ahb_lite_master u_dut (
    .hclk(hclk), .hreset(hreset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_write(req_write), .req_size(req_size),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
    .hwdata(hwdata), .hrdata(hrdata), .hready(hready), .hresp(hresp)
  );

  ahb_lite_master #(.MAX_RETRY(1)) u_dut1 (
    .hclk(hclk), .hreset(hreset), .req_valid(req_valid), .req_ready(u2_req_ready),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_write(req_write), .req_size(req_size),
    .rsp_valid(u2_rsp_valid), .rsp_rdata(u2_rsp_rdata), .rsp_err(u2_rsp_err),
    .haddr(u2_haddr), .htrans(u2_htrans), .hwrite(u2_hwrite), .hsize(u2_hsize),
    .hburst(u2_hburst), .hwdata(u2_hwdata), .hrdata(hrdata), .hready(hready), .hresp(hresp)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    #0;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic v, input logic [31:0] a, input logic [31:0] d,
                         input logic w);
    req_valid = v;
    req_addr  = a;
    req_wdata = d;
    req_write = w;
    req_size  = 3'd2;
  endtask

  task automatic set_slv(input logic rdy, input logic [1:0] rsp, input logic [31:0] rd);
    hready = rdy;
    hresp  = rsp;
    hrdata = rd;
    #1;
  endtask

  initial begin
    hreset = 1'b1;
    set_req(1'b0, 32'h0, 32'h0, 1'b0);
    set_slv(1'b1, 2'd0, 32'h0);
    step(); step();
    hreset = 1'b0;
    #1;
    chk("rst_htrans", 32'(htrans), 32'd0);
    chk("rst_haddr", haddr, 32'h0);
    chk("rst_hwdata", hwdata, 32'h0);
    chk("rst_hwrite", 32'(hwrite), 32'd0);
    chk("rst_hsize", 32'(hsize), 32'd0);
    chk("rst_hburst", 32'(hburst), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);

    // Zero-wait write
    set_req(1'b1, 32'h4, 32'hDEAD_BEEF, 1'b1); #1;
    chk("wr_ready", 32'(req_ready), 32'd1);
    step(); set_req(1'b0, 32'h0, 32'h0, 1'b0); #1;
    chk("wr_n1_htrans", 32'(htrans), 32'd2);
    chk("wr_n1_haddr", haddr, 32'h4);
    chk("wr_n1_hwrite", 32'(hwrite), 32'd1);
    chk("wr_n1_hsize", 32'(hsize), 32'd2);
    step();
    chk("wr_n2_htrans", 32'(htrans), 32'd0);
    chk("wr_n2_hwdata", hwdata, 32'hDEAD_BEEF);
    chk("wr_n2_rsp", 32'(rsp_valid), 32'd0);
    step();
    chk("wr_n3_rsp", 32'(rsp_valid), 32'd1);
    chk("wr_n3_err", 32'(rsp_err), 32'd0);
    chk("wr_n3_rdata", rsp_rdata, 32'h0);
    step();
    chk("wr_n4_rsp", 32'(rsp_valid), 32'd0);

    // Back-to-back reads
    set_req(1'b1, 32'h10, 32'h0, 1'b0); #1;
    chk("b2b_ready0", 32'(req_ready), 32'd1);
    step(); set_req(1'b1, 32'h14, 32'h0, 1'b0); #1;
    chk("b2b_c1_htrans", 32'(htrans), 32'd2);
    chk("b2b_c1_haddr", haddr, 32'h10);
    chk("b2b_ready1", 32'(req_ready), 32'd1);
    step(); set_req(1'b0, 32'h0, 32'h0, 1'b0); set_slv(1'b1, 2'd0, 32'h11);
    chk("b2b_c2_htrans", 32'(htrans), 32'd2);
    chk("b2b_c2_haddr", haddr, 32'h14);
    step(); set_slv(1'b1, 2'd0, 32'h22);
    chk("b2b_c3_rsp", 32'(rsp_valid), 32'd1);
    chk("b2b_c3_rdata", rsp_rdata, 32'h11);
    step();
    chk("b2b_c4_rsp", 32'(rsp_valid), 32'd1);
    chk("b2b_c4_rdata", rsp_rdata, 32'h22);
    step();
    chk("b2b_c5_rsp", 32'(rsp_valid), 32'd0);

    // Read with three wait states
    set_req(1'b1, 32'h30, 32'h0BAD_F00D, 1'b0);
    step(); set_req(1'b0, 32'h0, 32'h0, 1'b0);
    chk("ws_c1_haddr", haddr, 32'h30);
    step(); set_slv(1'b0, 2'd0, 32'h0);
    chk("ws_c2_hwdata", hwdata, 32'h0BAD_F00D);
    step();
    chk("ws_c3_haddr", haddr, 32'h30);
    chk("ws_c3_hwdata", hwdata, 32'h0BAD_F00D);
    chk("ws_c3_rsp", 32'(rsp_valid), 32'd0);
    step();
    chk("ws_c4_rsp", 32'(rsp_valid), 32'd0);
    step(); set_slv(1'b1, 2'd0, 32'h33);
    chk("ws_c5_rsp", 32'(rsp_valid), 32'd0);
    chk("ws_c5_hwdata", hwdata, 32'h0BAD_F00D);
    step(); set_slv(1'b1, 2'd0, 32'h0);
    chk("ws_c6_rsp", 32'(rsp_valid), 32'd1);
    chk("ws_c6_rdata", rsp_rdata, 32'h33);
    step();
    chk("ws_c7_rsp", 32'(rsp_valid), 32'd0);

    // ERROR on a write with a second write pending
    set_req(1'b1, 32'h40, 32'h1111, 1'b1);
    step(); set_req(1'b1, 32'h44, 32'h2222, 1'b1);
    step(); set_req(1'b0, 32'h0, 32'h0, 1'b0); set_slv(1'b0, 2'd1, 32'h0);
    chk("err_c2_htrans", 32'(htrans), 32'd2);
    chk("err_c2_haddr", haddr, 32'h44);
    chk("err_c2_hwdata", hwdata, 32'h1111);
    step(); set_slv(1'b1, 2'd1, 32'h0);
    chk("err_c3_htrans", 32'(htrans), 32'd0);
    chk("err_c3_ready", 32'(req_ready), 32'd0);
    chk("err_c3_rsp", 32'(rsp_valid), 32'd0);
    step(); set_slv(1'b1, 2'd0, 32'h0);
    chk("err_c4_rsp", 32'(rsp_valid), 32'd1);
    chk("err_c4_err", 32'(rsp_err), 32'd1);
    chk("err_c4_htrans", 32'(htrans), 32'd2);
    chk("err_c4_haddr", haddr, 32'h44);
    step();
    chk("err_c5_rsp", 32'(rsp_valid), 32'd0);
    chk("err_c5_hwdata", hwdata, 32'h2222);
    step();
    chk("err_c6_rsp", 32'(rsp_valid), 32'd1);
    chk("err_c6_err", 32'(rsp_err), 32'd0);

    // RETRY twice then OKAY; the MAX_RETRY=1 instance gives up on the second RETRY
    set_req(1'b1, 32'h20, 32'h0, 1'b0);
    step(); set_req(1'b0, 32'h0, 32'h0, 1'b0);
    chk("rty_c1_haddr", haddr, 32'h20);
    chk("rty_c1_htrans", 32'(htrans), 32'd2);
    step(); set_slv(1'b0, 2'd2, 32'h0);
    step(); set_slv(1'b1, 2'd2, 32'h0);
    chk("rty_c3_htrans", 32'(htrans), 32'd0);
    step(); set_slv(1'b1, 2'd0, 32'h0);
    chk("rty_c4_htrans", 32'(htrans), 32'd2);
    chk("rty_c4_haddr", haddr, 32'h20);
    chk("rty_c4_rsp", 32'(rsp_valid), 32'd0);
    chk("rty1_c4_htrans", 32'(u2_htrans), 32'd2);
    step(); set_slv(1'b0, 2'd2, 32'h0);
    step(); set_slv(1'b1, 2'd2, 32'h0);
    chk("rty_c6_htrans", 32'(htrans), 32'd0);
    chk("rty_c6_rsp", 32'(rsp_valid), 32'd0);
    step(); set_slv(1'b1, 2'd0, 32'h0);
    chk("rty_c7_htrans", 32'(htrans), 32'd2);
    chk("rty_c7_haddr", haddr, 32'h20);
    chk("rty_c7_rsp", 32'(rsp_valid), 32'd0);
    chk("rty1_c7_rsp", 32'(u2_rsp_valid), 32'd1);
    chk("rty1_c7_err", 32'(u2_rsp_err), 32'd1);
    chk("rty1_c7_htrans", 32'(u2_htrans), 32'd0);
    step(); set_slv(1'b1, 2'd0, 32'h2020);
    chk("rty_c8_rsp", 32'(rsp_valid), 32'd0);
    step(); set_slv(1'b1, 2'd0, 32'h0);
    chk("rty_c9_rsp", 32'(rsp_valid), 32'd1);
    chk("rty_c9_err", 32'(rsp_err), 32'd0);
    chk("rty_c9_rdata", rsp_rdata, 32'h2020);
    chk("rty1_c9_rsp", 32'(u2_rsp_valid), 32'd0);
    step();
    chk("rty_c10_rsp", 32'(rsp_valid), 32'd0);

    // Reset in the middle of a wait state
    set_req(1'b1, 32'h50, 32'h5555, 1'b1);
    step(); set_req(1'b0, 32'h0, 32'h0, 1'b0);
    step(); set_slv(1'b0, 2'd0, 32'h0);
    step(); hreset = 1'b1;
    step(); hreset = 1'b0; set_slv(1'b1, 2'd0, 32'h0);
    chk("mrst_htrans", 32'(htrans), 32'd0);
    chk("mrst_haddr", haddr, 32'h0);
    chk("mrst_hwdata", hwdata, 32'h0);
    chk("mrst_hwrite", 32'(hwrite), 32'd0);
    chk("mrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mrst_rsp_rdata", rsp_rdata, 32'h0);
    set_req(1'b1, 32'h60, 32'h0, 1'b0); #1;
    chk("mrst_ready", 32'(req_ready), 32'd1);
    step(); set_req(1'b0, 32'h0, 32'h0, 1'b0);
    chk("mrst_c1_htrans", 32'(htrans), 32'd2);
    chk("mrst_c1_haddr", haddr, 32'h60);
    chk("mrst_c1_rsp", 32'(rsp_valid), 32'd0);
    step(); set_slv(1'b1, 2'd0, 32'h66);
    chk("mrst_c2_rsp", 32'(rsp_valid), 32'd0);
    step(); set_slv(1'b1, 2'd0, 32'h0);
    chk("mrst_c3_rsp", 32'(rsp_valid), 32'd1);
    chk("mrst_c3_rdata", rsp_rdata, 32'h66);
    step();
    chk("mrst_c4_rsp", 32'(rsp_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
